// File: rtl/segscan_mux.sv
// Multiplexed N-digit common-anode 7-segment driver with per-frame input snapshots.
// Optional leading-zero blanking is enabled by defining SEGSCAN_LZB_EN.
module segscan_mux #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*NDIG-1:0]   value,
    input  logic [NDIG-1:0]     dp,
    input  logic [NDIG-1:0]     blank,
    output logic [7:0]          seg,
    output logic [NDIG-1:0]     an,
    output logic                frame
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [4*NDIG-1:0]  sv_q, sv_d;
    logic [NDIG-1:0]    sdp_q, sdp_d;
    logic [NDIG-1:0]    sbl_q, sbl_d;
    logic [7:0]         seg_q, seg_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic               frame_q, frame_d;

    logic [NDIG-1:0]    lzb;
    logic [3:0]         digit;
    logic               dark;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h18;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h27;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

`ifdef SEGSCAN_LZB_EN
    logic higher_zero;

    // Walk down from the top digit; a digit is blanked while everything above it is zero.
    always_comb begin
        lzb         = '0;
        higher_zero = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            higher_zero = higher_zero & (sv_q[4*i +: 4] == 4'h0);
            lzb[i]      = higher_zero;
        end
    end
`else
    always_comb begin
        lzb = '0;
    end
`endif

    always_comb begin
        digit   = sv_q[4*idx_q +: 4];
        dark    = (cnt_q < GUARD_C) || sbl_q[idx_q] || lzb[idx_q];

        cnt_d   = '0;
        idx_d   = '0;
        sv_d    = value;
        sdp_d   = dp;
        sbl_d   = blank;
        seg_d   = 8'hFF;
        an_d    = '1;
        frame_d = 1'b0;

        if (en) begin
            sv_d  = sv_q;
            sdp_d = sdp_q;
            sbl_d = sbl_q;
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (idx_q == IDX_MAX) begin
                    // Snapshot only at frame wrap so a frame never mixes two input values.
                    idx_d   = '0;
                    sv_d    = value;
                    sdp_d   = dp;
                    sbl_d   = blank;
                    frame_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            if (!dark) begin
                seg_d = {~sdp_q[idx_q], glyph(digit)};
                for (int i = 0; i < NDIG; i++) begin
                    an_d[i] = (idx_q != IW'(i));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            sv_q    <= '0;
            sdp_q   <= '0;
            sbl_q   <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sv_q    <= sv_d;
            sdp_q   <= sdp_d;
            sbl_q   <= sbl_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
